register_hazard_scheduler: RTL and testbench

Scoreboard-based issue controller for the register-access stage. Tracks in-flight writes to the eight x86 GPRs with a saturating counter per physical register, resolves 8-bit AH/CH/DH/BH aliasing, and stalls issue when any source operand or the destination is unsafe. Sits between decode and register access, next to the register file and its stall logic, and consumes the writeback port.

---
 rtl/reg_sched_pkg.sv | 27 ++
 rtl/reg_busy_counter.sv | 45 ++++
 rtl/register_hazard_scheduler.sv | 128 ++++++++++++
 tb/tb_register_hazard_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/reg_sched_pkg.sv
// reg_sched_pkg
// Shared definitions for the register hazard scheduler:
//   - operand size encodings (SZ_8 / SZ_16 / SZ_32, 3 = reserved, read as 32-bit)
//   - default register count and pending-write counter width
//   - alias_map(): folds the 8-bit high-byte registers AH/CH/DH/BH onto
//     their 32-bit parents EAX/ECX/EDX/EBX
package reg_sched_pkg;

    localparam int NUM_REGS_DEF = 8;
    localparam int CNT_W_DEF    = 2;
    localparam int REG_W        = 3;

    typedef enum logic [1:0] {
        SZ_8   = 2'd0,
        SZ_16  = 2'd1,
        SZ_32  = 2'd2,
        SZ_RSV = 2'd3
    } size_e;

    // In 8-bit mode, register numbers 4..7 encode AH/CH/DH/BH. These are
    // bits [15:8] of registers 0..3, so they share those registers' counters.
    function automatic logic [REG_W-1:0] alias_map(input logic [REG_W-1:0] r,
                                                   input logic [1:0]       sz);
        return (sz == SZ_8 && r[2]) ? {1'b0, r[1:0]} : r;
    endfunction

endpackage

// File: rtl/reg_busy_counter.sv
// reg_busy_counter
// One pending-write counter for a physical register. The counter saturates
// at both ends and never wraps.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clear           synchronous clear to 0; overrides inc/dec
//   inc             one more write in flight
//   dec             one write retired
//   cnt             current count
//   busy            cnt != 0
//   underflow       combinational: dec arrives while cnt == 0 (and no clear)
module reg_busy_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy      = (cnt != '0);
    // A retire against an empty counter means decode and writeback disagree.
    // This is reported even if an issue to the same register lands in the
    // same cycle.
    assign underflow = dec && !clear && (cnt == '0);

endmodule

// File: rtl/register_hazard_scheduler.sv
// register_hazard_scheduler
// Scoreboard issue controller for the register-access stage. A saturating
// pending-write counter per GPR tracks in-flight writes. Issue stalls while
// any used source has pending writes, or while the destination counter is
// saturated.
// Optional feature macro: REG_SCHED_BYPASS_EN. When defined, a source whose
// only pending write retires in the same cycle is taken from the writeback
// bus (fwd_srcN=1) and does not stall. When undefined, fwd_src* are tied to 0.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   dec_valid / dec_ready       decode handshake; issue = dec_valid & dec_ready
//   srcN_valid/reg/size         source operands (src2 = SIB index)
//   dst_valid/reg/size          destination operand
//   wb_enable/reg/size          writeback retiring one GPR write
//   flush                       clears all pending state; blocks issue
//   stall                       instruction held this cycle
//   busy_mask                   per-register counter != 0
//   fwd_src0/1/2                source taken from same-cycle writeback
//   err_underflow               sticky: writeback to a register with no pending write
module register_hazard_scheduler
    import reg_sched_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dec_valid,
    output logic                dec_ready,
    input  logic                src0_valid,
    input  logic [REG_W-1:0]    src0_reg,
    input  logic [1:0]          src0_size,
    input  logic                src1_valid,
    input  logic [REG_W-1:0]    src1_reg,
    input  logic [1:0]          src1_size,
    input  logic                src2_valid,
    input  logic [REG_W-1:0]    src2_reg,
    input  logic [1:0]          src2_size,
    input  logic                dst_valid,
    input  logic [REG_W-1:0]    dst_reg,
    input  logic [1:0]          dst_size,
    input  logic                wb_enable,
    input  logic [REG_W-1:0]    wb_reg,
    input  logic [1:0]          wb_size,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                fwd_src0,
    output logic                fwd_src1,
    output logic                fwd_src2,
    output logic                err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            inc, dec, uflow;

    logic [2:0]            src_vld;
    logic [2:0][REG_W-1:0] src_phys;
    logic [REG_W-1:0]      dst_phys, wb_phys;
    logic [2:0]            src_haz, fwd;
    logic                  dst_haz, issue;

    // Alias mapping for all operands.
    assign src_vld     = {src2_valid, src1_valid, src0_valid};
    assign src_phys[0] = alias_map(src0_reg, src0_size);
    assign src_phys[1] = alias_map(src1_reg, src1_size);
    assign src_phys[2] = alias_map(src2_reg, src2_size);
    assign dst_phys    = alias_map(dst_reg, dst_size);
    assign wb_phys     = alias_map(wb_reg, wb_size);

    // Source hazards, with optional same-cycle writeback bypass.
    always_comb begin
        src_haz = '0;
        fwd     = '0;
        for (int s = 0; s < 3; s++) begin
            src_haz[s] = src_vld[s] && (cnt[src_phys[s]] != '0);
`ifdef REG_SCHED_BYPASS_EN
            // Bypass is safe only if the retiring write is the last pending
            // write. With more writes still in flight, the value is not final.
            fwd[s] = src_vld[s] && wb_enable && (wb_phys == src_phys[s])
                     && (cnt[src_phys[s]] == CNT_W'(1));
            if (fwd[s]) src_haz[s] = 1'b0;
`endif
        end
    end

    assign dst_haz   = dst_valid && (cnt[dst_phys] == CNT_MAX);
    assign stall     = dec_valid && ((|src_haz) || dst_haz || flush);
    assign dec_ready = !stall;
    assign issue     = dec_valid && !stall;
    assign fwd_src0  = fwd[0];
    assign fwd_src1  = fwd[1];
    assign fwd_src2  = fwd[2];

    // Per-register increment and decrement strobes.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i] = issue && dst_valid && (dst_phys == REG_W'(i));
            dec[i] = wb_enable && (wb_phys == REG_W'(i));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_cnt
            reg_busy_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .clear     (flush),
                .inc       (inc[g]),
                .dec       (dec[g]),
                .cnt       (cnt[g]),
                .busy      (busy_mask[g]),
                .underflow (uflow[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      err_underflow <= 1'b0;
        else if (|uflow) err_underflow <= 1'b1;
    end

endmodule

// File: tb/tb_register_hazard_scheduler.sv
// Scoreboard bench for register_hazard_scheduler. Each stimulus cycle drives
// the inputs just after the rising edge and queues the expected outputs. A
// monitor compares them on the falling edge.
module tb_register_hazard_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid, dec_ready;
    logic       src0_valid, src1_valid, src2_valid;
    logic [2:0] src0_reg, src1_reg, src2_reg;
    logic [1:0] src0_size, src1_size, src2_size;
    logic       dst_valid;
    logic [2:0] dst_reg;
    logic [1:0] dst_size;
    logic       wb_enable;
    logic [2:0] wb_reg;
    logic [1:0] wb_size;
    logic       flush, stall;
    logic [7:0] busy_mask;
    logic       fwd_src0, fwd_src1, fwd_src2, err_underflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic       stall;
        logic [7:0] busy;
        logic [2:0] fwd;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

`ifdef REG_SCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    register_hazard_scheduler dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .src0_valid(src0_valid), .src0_reg(src0_reg), .src0_size(src0_size),
        .src1_valid(src1_valid), .src1_reg(src1_reg), .src1_size(src1_size),
        .src2_valid(src2_valid), .src2_reg(src2_reg), .src2_size(src2_size),
        .dst_valid(dst_valid), .dst_reg(dst_reg), .dst_size(dst_size),
        .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_size(wb_size),
        .flush(flush), .stall(stall), .busy_mask(busy_mask),
        .fwd_src0(fwd_src0), .fwd_src1(fwd_src1), .fwd_src2(fwd_src2),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: compare once per cycle whenever an expectation is pending.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".stall"},     {7'd0, stall},     {7'd0, e.stall});
            chk({e.name, ".dec_ready"}, {7'd0, dec_ready}, {7'd0, ~e.stall});
            chk({e.name, ".busy_mask"}, busy_mask,         e.busy);
            chk({e.name, ".fwd"},       {5'd0, fwd_src2, fwd_src1, fwd_src0}, {5'd0, e.fwd});
            chk({e.name, ".err"},       {7'd0, err_underflow}, {7'd0, e.err});
        end
    end

    task automatic idle_inputs();
        dec_valid = 0; flush = 0;
        src0_valid = 0; src0_reg = 0; src0_size = 2;
        src1_valid = 0; src1_reg = 0; src1_size = 2;
        src2_valid = 0; src2_reg = 0; src2_size = 2;
        dst_valid = 0;  dst_reg = 0;  dst_size = 2;
        wb_enable = 0;  wb_reg = 0;   wb_size = 2;
    endtask

    // Advance to just after the next rising edge, with idle inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic expect_out(input string nm, input logic st, input logic [7:0] b,
                              input logic [2:0] f, input logic er);
        exp_t x;
        x.name = nm; x.stall = st; x.busy = b; x.fwd = f; x.err = er;
        exp_q.push_back(x);
    endtask

    task automatic issue_dst(input logic [2:0] r, input logic [1:0] sz);
        dec_valid = 1; dst_valid = 1; dst_reg = r; dst_size = sz;
    endtask

    task automatic wb(input logic [2:0] r, input logic [1:0] sz);
        wb_enable = 1; wb_reg = r; wb_size = sz;
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        cyc(); expect_out("in_reset", 0, 8'h00, 0, 0);
        cyc(); reset = 1; expect_out("idle", 0, 8'h00, 0, 0);

        // AH write marks EAX busy; an EAX read stalls until the AH writeback.
        cyc(); issue_dst(4, 0);                       expect_out("alias_issue", 0, 8'h00, 0, 0);
        cyc(); dec_valid = 1; src0_valid = 1; src0_reg = 0; src0_size = 2;
               expect_out("alias_stall1", 1, 8'h01, 0, 0);
        cyc(); dec_valid = 1; src0_valid = 1; src0_reg = 0; src0_size = 2;
               expect_out("alias_stall2", 1, 8'h01, 0, 0);
        cyc(); dec_valid = 1; src0_valid = 1; src0_reg = 0; src0_size = 2; wb(4, 0);
               expect_out("alias_wb", !BYP, 8'h01, {2'b00, BYP}, 0);
        cyc(); dec_valid = 1; src0_valid = 1; src0_reg = 0; src0_size = 2;
               expect_out("alias_clear", 0, 8'h00, 0, 0);

        // Saturation of reg 3 at 3 pending writes.
        cyc(); issue_dst(3, 2); expect_out("sat_w1", 0, 8'h00, 0, 0);
        cyc(); issue_dst(3, 2); expect_out("sat_w2", 0, 8'h08, 0, 0);
        cyc(); issue_dst(3, 2); expect_out("sat_w3", 0, 8'h08, 0, 0);
        cyc(); issue_dst(3, 2); expect_out("sat_w4", 1, 8'h08, 0, 0);
        cyc(); issue_dst(5, 2); expect_out("sat_indep", 0, 8'h08, 0, 0);
        // BH (reg 7 in 8-bit mode) aliases to busy EBX; 16-bit reg 7 is free.
        cyc(); dec_valid = 1; src1_valid = 1; src1_reg = 7; src1_size = 0;
               expect_out("src_bh", 1, 8'h28, 0, 0);
        cyc(); dec_valid = 1; src2_valid = 1; src2_reg = 7; src2_size = 1;
               expect_out("src_di", 0, 8'h28, 0, 0);

        // Issue and writeback to the same register in one cycle cancel.
        cyc(); issue_dst(2, 2);         expect_out("sim_w1", 0, 8'h28, 0, 0);
        cyc(); issue_dst(2, 2); wb(2, 2); expect_out("sim_both", 0, 8'h2C, 0, 0);
        cyc();                          expect_out("sim_hold", 0, 8'h2C, 0, 0);
        cyc(); wb(2, 2);                expect_out("sim_wb", 0, 8'h2C, 0, 0);
        cyc();                          expect_out("sim_zero", 0, 8'h28, 0, 0);

        // Same-cycle writeback bypass on src1.
        cyc(); issue_dst(6, 2); expect_out("byp_w", 0, 8'h28, 0, 0);
        cyc(); dec_valid = 1; src1_valid = 1; src1_reg = 6; src1_size = 2; wb(6, 2);
               expect_out("byp", !BYP, 8'h68, {1'b0, BYP, 1'b0}, 0);
        cyc(); dec_valid = 1; src1_valid = 1; src1_reg = 6; src1_size = 2;
               expect_out("byp_after", 0, 8'h28, 0, 0);

        // Flush clears everything and blocks issue.
        cyc(); issue_dst(1, 2); flush = 1; expect_out("flush", 1, 8'h28, 0, 0);
        cyc(); flush = 1;                  expect_out("flush_nodec", 0, 8'h00, 0, 0);
        cyc(); wb(1, 2);                   expect_out("uf_wb", 0, 8'h00, 0, 0);
        cyc();                             expect_out("uf_set", 0, 8'h00, 0, 1);
        cyc(); flush = 1;                  expect_out("uf_flush", 0, 8'h00, 0, 1);
        cyc();                             expect_out("uf_hold", 0, 8'h00, 0, 1);

        // Asynchronous reset mid-operation.
        cyc(); issue_dst(0, 2);            expect_out("ar_issue", 0, 8'h00, 0, 1);
        cyc();                             expect_out("ar_busy", 0, 8'h01, 0, 1);
        cyc(); reset = 0;                  expect_out("ar_now", 0, 8'h00, 0, 0);
        cyc(); reset = 0; dec_valid = 1; flush = 1;
               expect_out("ar_flush", 1, 8'h00, 0, 0);
        cyc(); reset = 1;                  expect_out("ar_release", 0, 8'h00, 0, 0);

        // Wait for the monitor to drain the queue, with a bound.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
